// File: rtl/mem_access_stage.sv
// mem_access_stage: word load/store stage over a req/ack bus, owning the MEM/WB register.
// Rev 1.0 - initial release.
`default_nettype none

module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  i_wb_in,
  input  logic [1:0]  i_mem_ctl,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd_addr,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack,
  output logic [1:0]  o_wb_out,
  output logic [31:0] o_alu_result_wb,
  output logic [31:0] o_mem_rdata_wb,
  output logic [4:0]  o_rd_addr_wb,
  output logic        o_misalign_err,
  output logic        o_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [CW-1:0] r_cnt;
  logic        r_abort;
  logic [31:0] r_buf;
  logic        r_bus_err;

  logic [1:0]  r_wb_out;
  logic [31:0] r_alu_result_wb;
  logic [31:0] r_mem_rdata_wb;
  logic [4:0]  r_rd_addr_wb;

  logic        w_is_mem;
  logic        w_access_valid;
  logic        w_misaligned;
  logic        w_timeout_hit;
  logic        w_stall;
  logic        w_misalign_err;
  logic [1:0]  w_wb_nxt;
  logic [31:0] w_alu_nxt;
  logic [31:0] w_rdata_nxt;
  logic [4:0]  w_rd_nxt;

  // Opcode 11 is deliberately neither an access nor misaligned.
  assign w_is_mem       = (i_mem_ctl == 2'b01) || (i_mem_ctl == 2'b10);
  assign w_access_valid = w_is_mem && (i_alu_result[1:0] == 2'b00);
  assign w_misaligned   = w_is_mem && (i_alu_result[1:0] != 2'b00);
  assign w_timeout_hit  = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_stall        = 1'b0;
    w_misalign_err = 1'b0;
    w_wb_nxt       = 2'b00;
    w_alu_nxt      = 32'd0;
    w_rdata_nxt    = 32'd0;
    w_rd_nxt       = 5'd0;
    case (r_state)
      S_IDLE: begin
        if (w_access_valid) begin
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_misalign_err = w_misaligned;
          w_wb_nxt       = w_misaligned ? 2'b00 : i_wb_in;
          w_alu_nxt      = i_alu_result;
          w_rd_nxt       = i_rd_addr;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (i_bus_ack || w_timeout_hit) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_wb_nxt    = r_abort ? 2'b00 : i_wb_in;
        w_alu_nxt   = i_alu_result;
        w_rd_nxt    = i_rd_addr;
        w_rdata_nxt = r_buf;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_bus_req       <= 1'b0;
      r_bus_we        <= 1'b0;
      r_bus_addr      <= 32'd0;
      r_bus_wdata     <= 32'd0;
      r_cnt           <= '0;
      r_abort         <= 1'b0;
      r_buf           <= 32'd0;
      r_bus_err       <= 1'b0;
      r_wb_out        <= 2'b00;
      r_alu_result_wb <= 32'd0;
      r_mem_rdata_wb  <= 32'd0;
      r_rd_addr_wb    <= 5'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_wb_out        <= w_wb_nxt;
      r_alu_result_wb <= w_alu_nxt;
      r_mem_rdata_wb  <= w_rdata_nxt;
      r_rd_addr_wb    <= w_rd_nxt;
      r_bus_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access_valid) begin
            r_bus_addr  <= i_alu_result;
            r_bus_wdata <= i_store_data;
            r_bus_we    <= i_mem_ctl[0];
            r_bus_req   <= 1'b1;
            r_cnt       <= '0;
            // Cleared so stores and aborted loads write back zero load data.
            r_buf       <= 32'd0;
            r_abort     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
              r_buf <= i_bus_rdata;
            end
          end else if (w_timeout_hit) begin
            r_bus_req <= 1'b0;
            r_abort   <= 1'b1;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_abort <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_stall         = w_stall;
  assign o_misalign_err  = w_misalign_err;
  assign o_bus_req       = r_bus_req;
  assign o_bus_we        = r_bus_we;
  assign o_bus_addr      = r_bus_addr;
  assign o_bus_wdata     = r_bus_wdata;
  assign o_bus_err       = r_bus_err;
  assign o_wb_out        = r_wb_out;
  assign o_alu_result_wb = r_alu_result_wb;
  assign o_mem_rdata_wb  = r_mem_rdata_wb;
  assign o_rd_addr_wb    = r_rd_addr_wb;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage (TIMEOUT=4).
`default_nettype none

module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  i_wb_in;
  logic [1:0]  i_mem_ctl;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd_addr;
  logic        o_stall;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ack;
  logic [1:0]  o_wb_out;
  logic [31:0] o_alu_result_wb;
  logic [31:0] o_mem_rdata_wb;
  logic [4:0]  o_rd_addr_wb;
  logic        o_misalign_err;
  logic        o_bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.TIMEOUT(4)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .i_wb_in         (i_wb_in),
    .i_mem_ctl       (i_mem_ctl),
    .i_alu_result    (i_alu_result),
    .i_store_data    (i_store_data),
    .i_rd_addr       (i_rd_addr),
    .o_stall         (o_stall),
    .o_bus_req       (o_bus_req),
    .o_bus_we        (o_bus_we),
    .o_bus_addr      (o_bus_addr),
    .o_bus_wdata     (o_bus_wdata),
    .i_bus_rdata     (i_bus_rdata),
    .i_bus_ack       (i_bus_ack),
    .o_wb_out        (o_wb_out),
    .o_alu_result_wb (o_alu_result_wb),
    .o_mem_rdata_wb  (o_mem_rdata_wb),
    .o_rd_addr_wb    (o_rd_addr_wb),
    .o_misalign_err  (o_misalign_err),
    .o_bus_err       (o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] wb, input logic [1:0] ctl, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] rd);
    i_wb_in      = wb;
    i_mem_ctl    = ctl;
    i_alu_result = alu;
    i_store_data = sd;
    i_rd_addr    = rd;
  endtask

  // Holds the presented op until the DONE edge; ack_k=0 never acks.
  task automatic run_access(input int ack_k, input logic [31:0] rdata, input logic exp_we,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                            output int n_stall, output int n_req, output int n_err);
    int wcount;
    bit finished;
    wcount   = 0;
    n_stall  = 0;
    n_req    = 0;
    n_err    = 0;
    finished = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (o_bus_err) n_err++;
      if (o_bus_req) begin
        n_req++;
        wcount++;
        check_eq("bus_addr", o_bus_addr, exp_addr);
        check_eq("bus_we", {31'd0, o_bus_we}, {31'd0, exp_we});
        check_eq("bus_wdata", o_bus_wdata, exp_wdata);
        if (wcount == ack_k) begin
          i_bus_ack   = 1'b1;
          i_bus_rdata = rdata;
        end
      end
      if (o_stall) begin
        n_stall++;
        tick();
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'hBAD0BAD0;
      end else begin
        tick();
        finished = 1;
        break;
      end
    end
    check_eq("access_completes", {31'd0, finished}, 32'd1);
  endtask

  int ns, nr, ne;

  initial begin
    reset       = 1'b1;
    i_bus_ack   = 1'b0;
    i_bus_rdata = 32'd0;
    set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_bus_req", {31'd0, o_bus_req}, 32'd0);
    check_eq("rst_wb_out", {30'd0, o_wb_out}, 32'd0);
    check_eq("rst_alu_wb", o_alu_result_wb, 32'd0);
    check_eq("rst_rd_wb", {27'd0, o_rd_addr_wb}, 32'd0);
    check_eq("rst_bus_err", {31'd0, o_bus_err}, 32'd0);

    // ALU op
    set_op(2'b01, 2'b00, 32'h10, 32'd0, 5'd5);
    #1;
    check_eq("alu_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check_eq("alu_wb_out", {30'd0, o_wb_out}, 32'd1);
    check_eq("alu_result_wb", o_alu_result_wb, 32'h10);
    check_eq("alu_rd_wb", {27'd0, o_rd_addr_wb}, 32'd5);
    check_eq("alu_rdata_wb", o_mem_rdata_wb, 32'd0);

    // Load, ack on third WAIT cycle
    set_op(2'b10, 2'b10, 32'h100, 32'hAAAA, 5'd7);
    run_access(3, 32'hDEADBEEF, 1'b0, 32'h100, 32'hAAAA, ns, nr, ne);
    set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    check_eq("ld_stall_cycles", ns, 32'd4);
    check_eq("ld_req_cycles", nr, 32'd3);
    check_eq("ld_bus_err", ne, 32'd0);
    check_eq("ld_rdata_wb", o_mem_rdata_wb, 32'hDEADBEEF);
    check_eq("ld_rd_wb", {27'd0, o_rd_addr_wb}, 32'd7);
    check_eq("ld_wb_out", {30'd0, o_wb_out}, 32'd2);
    check_eq("ld_alu_wb", o_alu_result_wb, 32'h100);

    // Store, immediate ack
    set_op(2'b10, 2'b01, 32'h204, 32'h1234, 5'd3);
    run_access(1, 32'hFFFF0000, 1'b1, 32'h204, 32'h1234, ns, nr, ne);
    set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    check_eq("st_stall_cycles", ns, 32'd2);
    check_eq("st_req_cycles", nr, 32'd1);
    check_eq("st_rdata_wb", o_mem_rdata_wb, 32'd0);
    check_eq("st_wb_out", {30'd0, o_wb_out}, 32'd2);
    check_eq("st_alu_wb", o_alu_result_wb, 32'h204);

    // Misaligned load
    set_op(2'b01, 2'b10, 32'h102, 32'd0, 5'd4);
    #1;
    check_eq("mis_err", {31'd0, o_misalign_err}, 32'd1);
    check_eq("mis_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check_eq("mis_wb_out", {30'd0, o_wb_out}, 32'd0);
    check_eq("mis_bus_req", {31'd0, o_bus_req}, 32'd0);
    set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    #1;
    check_eq("mis_err_clear", {31'd0, o_misalign_err}, 32'd0);
    tick();
    check_eq("mis_bus_req2", {31'd0, o_bus_req}, 32'd0);

    // Timeout with no ack
    set_op(2'b01, 2'b10, 32'h300, 32'd0, 5'd9);
    run_access(0, 32'd0, 1'b0, 32'h300, 32'd0, ns, nr, ne);
    set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    check_eq("to_req_cycles", nr, 32'd4);
    check_eq("to_stall_cycles", ns, 32'd5);
    check_eq("to_bus_err_pulses", ne, 32'd1);
    check_eq("to_wb_out", {30'd0, o_wb_out}, 32'd0);
    check_eq("to_rd_wb", {27'd0, o_rd_addr_wb}, 32'd9);
    check_eq("to_bus_err_clear", {31'd0, o_bus_err}, 32'd0);
    #1;
    check_eq("to_idle_stall", {31'd0, o_stall}, 32'd0);

    // Reset during WAIT, late ack ignored
    set_op(2'b01, 2'b10, 32'h400, 32'd0, 5'd6);
    tick();
    tick();
    check_eq("rw_req_in_wait", {31'd0, o_bus_req}, 32'd1);
    reset = 1'b1;
    set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    reset = 1'b0;
    check_eq("rw_bus_req", {31'd0, o_bus_req}, 32'd0);
    check_eq("rw_bus_addr", o_bus_addr, 32'd0);
    check_eq("rw_rd_wb", {27'd0, o_rd_addr_wb}, 32'd0);
    tick();
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'hCAFEF00D;
    tick();
    i_bus_ack = 1'b0;
    check_eq("rw_ack_ignored_req", {31'd0, o_bus_req}, 32'd0);
    check_eq("rw_ack_ignored_rdata", o_mem_rdata_wb, 32'd0);
    set_op(2'b11, 2'b00, 32'h55, 32'd0, 5'd12);
    #1;
    check_eq("rw_alu_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check_eq("rw_alu_wb_out", {30'd0, o_wb_out}, 32'd3);
    check_eq("rw_alu_result", o_alu_result_wb, 32'h55);
    check_eq("rw_alu_rd", {27'd0, o_rd_addr_wb}, 32'd12);
    check_eq("rw_alu_rdata", o_mem_rdata_wb, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
